// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the buffered UART receiver (uart_rx_fifo) and its
// FIFO (uart_rx_buf): receiver state encoding, default parameters and a
// 2-of-3 majority helper.
//
// Optional feature macro: UART_RX_MAJORITY_EN (off by default). When defined,
// every start/data/stop sample is the majority of three consecutive samples
// around the nominal point. Enable it by uncommenting the line below or by
// defining it on the tool command line.
// ---------------------------------------------------------------------------
// `define UART_RX_MAJORITY_EN

package uart_rx_fifo_pkg;

   // 50 MHz / 115200 baud
   localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
   localparam int UART_DEPTH_DEFAULT        = 16;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// ---------------------------------------------------------------------------
// uart_rx_buf
// Synchronous first-word-fall-through FIFO of bytes.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   wr, din   - push request and data
//   rd        - pop request; ignored while empty
//   dout      - head entry (holds last value when empty, 8'h00 after reset)
//   empty     - no entries held
//   full      - DEPTH entries held
//   count     - entries held, 0..DEPTH
//   drop      - a push was attempted while full with no pop in the same cycle
//
// Handshake: a push is accepted when not full, or when full and a pop happens
// in the same cycle. A pop is accepted whenever the FIFO is not empty.
//
// No configuration macros are used in this file.
// ---------------------------------------------------------------------------
module uart_rx_buf #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr,
   input  logic [7:0]                 din,
   input  logic                       rd,
   output logic [7:0]                 dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    dout_q, dout_d;
   logic [AW-1:0] rd_next;
   logic          do_pop, do_push, is_full, is_empty;

   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == CW'(DEPTH));
      do_pop   = rd && !is_empty;
      do_push  = wr && (!is_full || do_pop);
      rd_next  = rd_ptr_q + 1'b1;
      rd_ptr_d = do_pop  ? rd_next : rd_ptr_q;
      wr_ptr_d = do_push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);

      // dout is a registered copy of the head; work out the head after
      // this edge. With one entry left, a pop plus push makes din the head.
      dout_d = dout_q;
      if (do_pop) begin
         if (count_q > CW'(1))
            dout_d = mem_q[rd_next];
         else if (do_push)
            dout_d = din;
      end else if (do_push && is_empty) begin
         dout_d = din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= 8'h00;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   // Storage needs no reset: nothing is read before it is written.
   always_ff @(posedge clk) begin
      if (!rst && do_push)
         mem_q[wr_ptr_q] <= din;
   end

   assign dout  = dout_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign count = count_q;
   assign drop  = wr && is_full && !do_pop;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Buffered 8N1 UART receiver, LSB first, mid-bit sampling, feeding a FWFT
// FIFO (uart_rx_buf) drained by the CPU bus interface.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   ser_rxd    - asynchronous serial input, idles high
//   rd_req     - one-cycle pop of the FIFO head
//   err_clr    - clears the sticky error flags (a same-cycle set wins)
//   dout       - FIFO head byte, valid while rxd_rdy=1
//   rxd_rdy    - FIFO not empty
//   full       - FIFO holds DEPTH entries
//   count      - entries held
//   overrun    - sticky: a received byte was dropped, FIFO full
//   frame_err  - sticky: a stop bit was sampled as 0
//   dbg_state  - current receiver state (rx_state_e encoding)
//
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling at nominal-1,
// nominal and nominal+1; the decision lands one cycle after the nominal
// point while bit timing still runs from the nominal point.
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int DEPTH        = UART_DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ser_rxd,
   input  logic                       rd_req,
   input  logic                       err_clr,
   output logic [7:0]                 dout,
   output logic                       rxd_rdy,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overrun,
   output logic                       frame_err,
   output logic [2:0]                 dbg_state
);
   localparam int            BW      = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST    = BW'(CLKS_PER_BIT - 1);

   rx_state_e     state_q, state_d;
   logic          s1_q, s1_d, s2_q, s2_d;
   logic [BW-1:0] bctr_q, bctr_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    sr_q, sr_d;
   logic          overrun_q, overrun_d;
   logic          frame_err_q, frame_err_d;
   logic          rxs, push, fe_set, fifo_drop, fifo_empty;

`ifdef UART_RX_MAJORITY_EN
   // rxs_prev_q provides the nominal-1 sample; at the nominal point the two
   // early samples are latched and the decision is taken one cycle later.
   logic      rxs_prev_q;
   logic      pend_q, pend_d;
   rx_state_e pend_kind_q, pend_kind_d;
   logic      maj_a_q, maj_a_d, maj_b_q, maj_b_d;
   logic      maj;
`endif

   always_comb begin
      s1_d        = ser_rxd;
      s2_d        = s1_q;
      rxs         = s2_q;
      state_d     = state_q;
      bctr_d      = bctr_q + 1'b1;
      bit_idx_d   = bit_idx_q;
      sr_d        = sr_q;
      push        = 1'b0;
      fe_set      = 1'b0;
`ifdef UART_RX_MAJORITY_EN
      pend_d      = 1'b0;
      pend_kind_d = pend_kind_q;
      maj_a_d     = maj_a_q;
      maj_b_d     = maj_b_q;
      maj         = maj3(maj_a_q, maj_b_q, rxs);
`endif

      case (state_q)
         RX_IDLE: begin
            bctr_d = '0;
            if (!rxs)
               state_d = RX_START;
         end
         RX_START: begin
            if (bctr_q == HALF_M1) begin
               bctr_d = '0;
`ifdef UART_RX_MAJORITY_EN
               // Enter DATA speculatively; a false start is undone next cycle.
               state_d     = RX_DATA;
               bit_idx_d   = '0;
               pend_d      = 1'b1;
               pend_kind_d = RX_START;
               maj_a_d     = rxs_prev_q;
               maj_b_d     = rxs;
`else
               if (rxs) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d   = RX_DATA;
                  bit_idx_d = '0;
               end
`endif
            end
         end
         RX_DATA: begin
            if (bctr_q == LAST) begin
               bctr_d    = '0;
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7)
                  state_d = RX_STOP;
`ifdef UART_RX_MAJORITY_EN
               pend_d      = 1'b1;
               pend_kind_d = RX_DATA;
               maj_a_d     = rxs_prev_q;
               maj_b_d     = rxs;
`else
               sr_d = {rxs, sr_q[7:1]};
`endif
            end
         end
         RX_STOP: begin
            if (bctr_q == LAST) begin
               bctr_d = '0;
`ifdef UART_RX_MAJORITY_EN
               state_d     = RX_IDLE;
               pend_d      = 1'b1;
               pend_kind_d = RX_STOP;
               maj_a_d     = rxs_prev_q;
               maj_b_d     = rxs;
`else
               if (rxs) begin
                  push    = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_d = RX_BREAK;
               end
`endif
            end
         end
         RX_BREAK: begin
            // Hold here until the line goes idle so a stuck-low line cannot
            // be mistaken for a stream of start bits.
            bctr_d = '0;
            if (rxs)
               state_d = RX_IDLE;
         end
         default: begin
            bctr_d  = '0;
            state_d = RX_IDLE;
         end
      endcase

`ifdef UART_RX_MAJORITY_EN
      // Deferred decisions override the speculative schedule above.
      if (pend_q) begin
         case (pend_kind_q)
            RX_START: begin
               if (maj) begin
                  state_d = RX_IDLE;
                  bctr_d  = '0;
               end
            end
            RX_DATA: sr_d = {maj, sr_q[7:1]};
            RX_STOP: begin
               if (maj) begin
                  push = 1'b1;
               end else begin
                  fe_set  = 1'b1;
                  state_d = RX_BREAK;
                  bctr_d  = '0;
               end
            end
            default: ;
         endcase
      end
`endif

      // Set wins over a same-cycle clear.
      overrun_d   = (overrun_q & ~err_clr) | fifo_drop;
      frame_err_d = (frame_err_q & ~err_clr) | fe_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= 1'b1;
         s2_q        <= 1'b1;
         state_q     <= RX_IDLE;
         bctr_q      <= '0;
         bit_idx_q   <= '0;
         sr_q        <= 8'h00;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         state_q     <= state_d;
         bctr_q      <= bctr_d;
         bit_idx_q   <= bit_idx_d;
         sr_q        <= sr_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rxs_prev_q  <= 1'b1;
         pend_q      <= 1'b0;
         pend_kind_q <= RX_IDLE;
         maj_a_q     <= 1'b1;
         maj_b_q     <= 1'b1;
      end else begin
         rxs_prev_q  <= rxs;
         pend_q      <= pend_d;
         pend_kind_q <= pend_kind_d;
         maj_a_q     <= maj_a_d;
         maj_b_q     <= maj_b_d;
      end
   end
`endif

   uart_rx_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .wr    (push),
      .din   (sr_q),
      .rd    (rd_req),
      .dout  (dout),
      .empty (fifo_empty),
      .full  (full),
      .count (count),
      .drop  (fifo_drop)
   );

   assign rxd_rdy   = ~fifo_empty;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo with CLKS_PER_BIT=16, DEPTH=4. Frames are driven
// onto ser_rxd; each frame schedules its effect (byte or framing error) at
// a fixed cycle offset from its falling start edge. A queue-based model of
// the FIFO and sticky flags is compared with the DUT every cycle.
// Honours UART_RX_MAJORITY_EN (one extra cycle of latency, spike test).
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int H     = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 3 + H + 9 * CPB + 1;
`else
   localparam int LAT = 3 + H + 9 * CPB;
`endif

   logic                       clk = 1'b0;
   logic                       rst, ser_rxd, rd_req, err_clr;
   logic [7:0]                 dout;
   logic                       rxd_rdy, full, overrun, frame_err;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic [2:0]                 dbg_state;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ser_rxd   (ser_rxd),
      .rd_req    (rd_req),
      .err_clr   (err_clr),
      .dout      (dout),
      .rxd_rdy   (rxd_rdy),
      .full      (full),
      .count     (count),
      .overrun   (overrun),
      .frame_err (frame_err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       ok;
   } ev_t;

   ev_t        ev_q[$];
   logic [7:0] exp_q[$];
   logic       m_ovr = 1'b0;
   logic       m_fe  = 1'b0;
   bit         m_pop, m_was_full, m_ovr_set, m_fe_set;
   ev_t        m_ev;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         ev_q.delete();
         m_ovr = 1'b0;
         m_fe  = 1'b0;
      end else begin
         m_pop      = rd_req && (exp_q.size() > 0);
         m_was_full = (exp_q.size() == DEPTH);
         m_ovr_set  = 1'b0;
         m_fe_set   = 1'b0;
         if (m_pop)
            void'(exp_q.pop_front());
         if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
            m_ev = ev_q.pop_front();
            if (m_ev.ok) begin
               if (!m_was_full || m_pop)
                  exp_q.push_back(m_ev.data);
               else
                  m_ovr_set = 1'b1;
            end else begin
               m_fe_set = 1'b1;
            end
         end
         if (err_clr) begin
            m_ovr = 1'b0;
            m_fe  = 1'b0;
         end
         if (m_ovr_set) m_ovr = 1'b1;
         if (m_fe_set)  m_fe  = 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rxd_rdy",   32'(rxd_rdy),   32'(exp_q.size() > 0));
         chk("count",     32'(count),     32'(exp_q.size()));
         chk("full",      32'(full),      32'(exp_q.size() == DEPTH));
         chk("overrun",   32'(overrun),   32'(m_ovr));
         chk("frame_err", 32'(frame_err), 32'(m_fe));
         if (exp_q.size() > 0)
            chk("dout", 32'(dout), 32'(exp_q[0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic clr_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   // Drives one frame starting now; spike_bit>=0 inverts that data bit for
   // one clock exactly at its nominal sample point.
   task automatic send_frame(input logic [7:0] d, input logic stop_b,
                             input int extra_low, input int spike_bit);
      ev_q.push_back('{cyc: cyc + LAT, data: d, ok: stop_b});
      ser_rxd = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < CPB; k++) begin
            ser_rxd = (i == spike_bit && k == H) ? ~d[i] : d[i];
            tick();
         end
      end
      ser_rxd = stop_b;
      repeat (CPB) tick();
      repeat (extra_low) tick();
      ser_rxd = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   bit         done_send;
   int         n0;
   logic [7:0] c3 = 8'hC3;
   logic [7:0] seq4 [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
   logic [7:0] tail4 [4] = '{8'h80, 8'hFF, 8'h00, 8'h77};

   initial begin
      rst = 1'b1; ser_rxd = 1'b1; rd_req = 1'b0; err_clr = 1'b0;
      tick();
      chk_en = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("reset dout",      32'(dout),      32'h00);
      chk("reset rxd_rdy",   32'(rxd_rdy),   32'h0);
      chk("reset count",     32'(count),     32'h0);
      chk("reset state",     32'(dbg_state), 32'h0);

      // Single byte, then pop
      send_frame(8'hA5, 1'b1, 0, -1);
      chk("a5 dout",  32'(dout),    32'hA5);
      chk("a5 count", 32'(count),   32'h1);
      pop();
      chk("a5 popped rdy",   32'(rxd_rdy), 32'h0);
      chk("a5 popped count", 32'(count),   32'h0);

      // Fill the FIFO back to back
      for (int i = 0; i < 4; i++) send_frame(seq4[i], 1'b1, 0, -1);
      chk("fill full",    32'(full),    32'h1);
      chk("fill count",   32'(count),   32'h4);
      chk("fill overrun", 32'(overrun), 32'h0);

      // Overrun
      send_frame(8'h3C, 1'b1, 0, -1);
      chk("ovr flag",  32'(overrun), 32'h1);
      chk("ovr count", 32'(count),   32'h4);
      chk("ovr head",  32'(dout),    32'h01);
      clr_err();
      chk("ovr cleared", 32'(overrun), 32'h0);

      // Push coinciding with pop while full
      n0 = cyc;
      fork
         send_frame(8'h77, 1'b1, 0, -1);
         begin
            while (cyc != n0 + LAT - 1) tick();
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
         end
      join
      chk("pp count",   32'(count),   32'h4);
      chk("pp overrun", 32'(overrun), 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("pp drain", 32'(dout), 32'(tail4[i]));
         pop();
      end

      // Random traffic with concurrent reads and clears
      done_send = 1'b0;
      fork
         begin
            for (int f = 0; f < 24; f++) begin
               repeat ($urandom_range(0, 30)) tick();
               if ($urandom_range(0, 7) == 0) begin
                  send_frame(8'($urandom), 1'b0, $urandom_range(0, 30), -1);
                  repeat (4) tick();
               end else begin
                  send_frame(8'($urandom), 1'b1, 0, -1);
               end
            end
            repeat (4) tick();
            done_send = 1'b1;
         end
         begin
            while (!done_send) begin
               rd_req  = ($urandom_range(0, 5) == 0);
               err_clr = ($urandom_range(0, 40) == 0);
               tick();
            end
            rd_req  = 1'b0;
            err_clr = 1'b0;
         end
      join
      for (int i = 0; i <= DEPTH && rxd_rdy; i++) pop();
      clr_err();

      // Short glitch: no byte, no flag
      ser_rxd = 1'b0;
      repeat (6) tick();
      ser_rxd = 1'b1;
      repeat (2 * CPB) tick();
      chk("glitch count", 32'(count),     32'h0);
      chk("glitch fe",    32'(frame_err), 32'h0);

      // Bad stop with line held low, then recovery
      send_frame(8'h00, 1'b0, 40, -1);
      repeat (4) tick();
      chk("break fe",    32'(frame_err), 32'h1);
      chk("break count", 32'(count),     32'h0);
      send_frame(8'h55, 1'b1, 0, -1);
      chk("after break dout", 32'(dout), 32'h55);
      pop();
      clr_err();

      // Reset during data bit 4
      ser_rxd = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 4; i++) begin
         ser_rxd = c3[i];
         repeat (CPB) tick();
      end
      ser_rxd = c3[4];
      repeat (H) tick();
      rst = 1'b1;
      ser_rxd = 1'b1;
      repeat (2) tick();
      chk("midrst dout",  32'(dout),      32'h00);
      chk("midrst rdy",   32'(rxd_rdy),   32'h0);
      chk("midrst fe",    32'(frame_err), 32'h0);
      chk("midrst state", 32'(dbg_state), 32'h0);
      rst = 1'b0;
      repeat (4) tick();
`ifdef UART_RX_MAJORITY_EN
      send_frame(8'hC3, 1'b1, 0, 2);
`else
      send_frame(8'hC3, 1'b1, 0, -1);
`endif
      chk("c3 dout",  32'(dout),  32'hC3);
      chk("c3 count", 32'(count), 32'h1);
      pop();
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
